// File: rtl/fixed_arith_seq.sv
// Signed fixed-point operator: loads A then B from a shared bus, then runs
// either a single-cycle add or a W-cycle shift-add multiply, holding the
// result and overflow flag until the next operation completes.
module fixed_arith_seq #(
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int SAT  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_in,
  input  logic         load,
  input  logic         op_add,
  input  logic         op_mul,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic [2:0]   state,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0]   MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   MIN_NEG = {1'b1, {(W-1){1'b0}}};
  // Magnitude limits for the shifted product, widened to the accumulator.
  localparam logic [2*W-1:0] LIM_POS = {{W{1'b0}}, MAX_POS};
  localparam logic [2*W-1:0] LIM_NEG = {{W{1'b0}}, MIN_NEG};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    MULT    = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]   a, b;
  logic [2*W-1:0] acc, mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  logic ld_a, ld_b, start_mul, fin_add, fin_mul;

  // Unsigned magnitude; the most negative value maps to 2^(W-1).
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    mag = x[W-1] ? (~x + W'(1)) : x;
  endfunction

  logic [W:0]     sum_x;
  logic           add_ovf;
  logic [W-1:0]   add_res;
  logic [2*W-1:0] acc_next, m_shift;
  logic           neg, mul_ovf;
  logic [W-1:0]   mul_wrap, mul_res;

  // Add/multiply result formation including wrap or saturate.
  always_comb begin
    sum_x    = {a[W-1], a} + {b[W-1], b};
    add_ovf  = sum_x[W] ^ sum_x[W-1];
    add_res  = (SAT != 0 && add_ovf) ? (sum_x[W] ? MIN_NEG : MAX_POS) : sum_x[W-1:0];
    acc_next = mplier[0] ? (acc + mcand) : acc;
    m_shift  = acc_next >> FRAC;
    neg      = a[W-1] ^ b[W-1];
    mul_ovf  = neg ? (m_shift > LIM_NEG) : (m_shift > LIM_POS);
    mul_wrap = neg ? (~m_shift[W-1:0] + W'(1)) : m_shift[W-1:0];
    mul_res  = (SAT != 0 && mul_ovf) ? (neg ? MIN_NEG : MAX_POS) : mul_wrap;
  end

  // Next-state and datapath strobes; op_mul beats op_add, ops beat load.
  always_comb begin
    state_d   = state_q;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    start_mul = 1'b0;
    fin_add   = 1'b0;
    fin_mul   = 1'b0;
    case (state_q)
      IDLE: if (load) begin
        ld_a    = 1'b1;
        state_d = WAIT_B;
      end
      WAIT_B: if (load) begin
        ld_b    = 1'b1;
        state_d = WAIT_OP;
      end
      WAIT_OP: begin
        if (op_mul) begin
          start_mul = 1'b1;
          state_d   = MULT;
        end else if (op_add) begin
          fin_add = 1'b1;
          state_d = RESULT;
        end
      end
      MULT: if (cnt == CW'(W-1)) begin
        fin_mul = 1'b1;
        state_d = RESULT;
      end
      RESULT: if (load) begin
        ld_a    = 1'b1;
        state_d = WAIT_B;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Operand capture and shift-add multiplier, one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      if (ld_a) a <= data_in;
      if (ld_b) b <= data_in;
      if (start_mul) begin
        acc    <= '0;
        mcand  <= {{W{1'b0}}, mag(a)};
        mplier <= mag(b);
        cnt    <= '0;
      end else if (state_q == MULT) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
    end
  end

  // Result/overflow registers updated only when an operation completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= fin_add | fin_mul;
      if (fin_add) begin
        result   <= add_res;
        overflow <= add_ovf;
      end else if (fin_mul) begin
        result   <= mul_res;
        overflow <= mul_ovf;
      end
    end
  end

  assign state = state_q;
  assign busy  = (state_q == MULT);

endmodule

// File: tb/tb_fixed_arith_seq.sv
// Scoreboard bench: wrap and saturate instances share stimulus; expected
// results come from an integer model and are checked when done pulses.
module tb_fixed_arith_seq;
  localparam int W = 16, FRAC = 8;

  logic clk = 1'b0, rst = 1'b0;
  logic [W-1:0] data_in = '0;
  logic load = 1'b0, op_add = 1'b0, op_mul = 1'b0;
  logic [W-1:0] r0, r1;
  logic o0, o1, bz0, bz1, d0, d1;
  logic [2:0] st0, st1;

  fixed_arith_seq #(.W(W), .FRAC(FRAC), .SAT(0)) u0 (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .op_add(op_add), .op_mul(op_mul),
    .result(r0), .overflow(o0), .state(st0), .busy(bz0), .done(d0));
  fixed_arith_seq #(.W(W), .FRAC(FRAC), .SAT(1)) u1 (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .op_add(op_add), .op_mul(op_mul),
    .result(r1), .overflow(o1), .state(st1), .busy(bz1), .done(d1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct {
    logic [W-1:0] r;
    bit           o;
    int           at;
  } exp_t;
  exp_t q0[$], q1[$];
  logic [W-1:0] last0 = '0, last1 = '0;
  bit in_result = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Fixed-point reference: plain integer arithmetic on real values.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit mul, input bit sat,
                                output logic [W-1:0] r, output bit o);
    longint sa, sb, pa, pb, m, v;
    longint maxp, minn;
    logic [63:0] t;
    bit neg;
    maxp = (64'sd1 <<< (W-1)) - 1;
    minn = -(64'sd1 <<< (W-1));
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!mul) begin
      v = sa + sb;
      o = (v > maxp) || (v < minn);
    end else begin
      pa  = (sa < 0) ? -sa : sa;
      pb  = (sb < 0) ? -sb : sb;
      m   = (pa * pb) / (64'sd1 <<< FRAC);
      neg = (sa < 0) != (sb < 0);
      o   = neg ? (m > maxp + 1) : (m > maxp);
      v   = neg ? -m : m;
    end
    t = v;
    if (sat && o) r = (v < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else          r = t[W-1:0];
  endfunction

  // Monitor: pop expected entry on each done pulse and compare.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (d0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL done0_unexpected: got done=1 want no pending op (cycle %0d)", cyc);
        end else begin
          e = q0.pop_front();
          check("res_wrap", r0, e.r);
          check("ovf_wrap", o0, e.o);
          check("lat_wrap", cyc, e.at);
        end
      end
      if (d1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL done1_unexpected: got done=1 want no pending op (cycle %0d)", cyc);
        end else begin
          e = q1.pop_front();
          check("res_sat", r1, e.r);
          check("ovf_sat", o1, e.o);
          check("lat_sat", cyc, e.at);
        end
      end
    end
  end

  // Drive one cycle of strobes; entered and left #1 after a rising edge.
  task automatic strobe(input logic ld, input logic ad, input logic mu, input logic [W-1:0] d);
    load = ld; op_add = ad; op_mul = mu; data_in = d;
    @(posedge clk); #1;
    load = 1'b0; op_add = 1'b0; op_mul = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit mul,
                        input bit both, input bit ld_with_op, input bit junk);
    logic [W-1:0] e0, e1;
    bit eo0, eo1, seen;
    int busy_n;
    if (in_result) begin
      if (junk) begin
        strobe(1'b0, 1'b1, 1'b1, a);
        check("st_result_ops", st0, 4);
      end
      strobe(1'b1, 1'b0, 1'b0, a);
      check("st_load_in_result", st0, 1);
      check("res_wrap_held", r0, last0);
      check("res_sat_held", r1, last1);
    end else begin
      if (junk) begin
        strobe(1'b0, 1'b1, 1'b1, a);
        check("st_idle_ops", st0, 0);
      end
      strobe(1'b1, 1'b0, 1'b0, a);
    end
    if (junk) begin
      strobe(1'b0, 1'b1, 1'b0, b);
      strobe(1'b0, 1'b0, 1'b1, b);
      check("st_waitb_ops", st0, 1);
    end
    strobe(1'b1, 1'b0, 1'b0, b);
    check("st_waitop", st1, 2);
    model(a, b, mul, 1'b0, e0, eo0);
    model(a, b, mul, 1'b1, e1, eo1);
    q0.push_back('{e0, eo0, cyc + (mul ? W + 1 : 1)});
    q1.push_back('{e1, eo1, cyc + (mul ? W + 1 : 1)});
    strobe(ld_with_op, !mul || both, mul, W'($urandom));
    busy_n = 0;
    seen = 1'b0;
    for (int i = 0; i < W + 8 && !seen; i++) begin
      @(negedge clk);
      if (d0) seen = 1'b1;
      else if (bz0) busy_n++;
    end
    check("done_seen", seen, 1);
    check("busy_cycles", busy_n, mul ? W : 0);
    @(posedge clk); #1;
    last0 = e0;
    last1 = e1;
    in_result = 1'b1;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edge_v [6];
    edge_v = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0100, 16'hFF00};
    if ($urandom_range(0, 3) == 0) pick = edge_v[$urandom_range(0, 5)];
    else                           pick = W'($urandom);
  endfunction

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", st0, 0);
    check("rst_result", r0, 0);
    check("rst_ovf", o0, 0);
    check("rst_busy", bz0, 0);
    check("rst_done", d1, 0);
    check("rst_result_sat", r1, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(16'h0180, 16'h0240, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(16'h0180, 16'h0240, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op(16'hFE80, 16'h0240, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(16'h7F00, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(16'h4000, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(16'h0180, 16'h0240, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op(16'h0300, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(16'h0300, 16'hFD00, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a multiply: no result update, no done.
    strobe(1'b1, 1'b0, 1'b0, 16'h0180);
    strobe(1'b1, 1'b0, 1'b0, 16'h0240);
    strobe(1'b0, 1'b0, 1'b1, 16'h0000);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midmul_state", st0, 0);
    check("midmul_result", r0, 0);
    check("midmul_ovf", o0, 0);
    check("midmul_busy", bz1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (W + 8) @(posedge clk);
    #1;
    check("midmul_idle", st0, 0);
    in_result = 1'b0;
    last0 = '0;
    last1 = '0;

    // Randomized operations.
    for (int k = 0; k < 40; k++)
      run_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));

    repeat (4) @(posedge clk);
    check("q_wrap_drained", q0.size(), 0);
    check("q_sat_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_arith_seq.md
Name: fixed_arith_seq

Overview:
- Parametrised successor to the board-level fixed-point operator front end.
- Captures two signed fixed-point operands from a shared data bus over successive load strobes, then performs an add or a multi-cycle shift-add multiply on command.
- Holds the result and an overflow flag until the next operation completes.
- Sits between the debounced switch/button inputs and the LED/SSD display path; generalises operand width, fraction position and overflow handling (wrap or saturate).

Parameters:
- W, 16: operand/result width in bits. Signed two's complement; W >= 4.
- FRAC, 8: number of fraction bits. 0 <= FRAC < W.
- SAT, 0: overflow handling. 0 = wrap (keep low W bits); 1 = saturate to 2^(W-1)-1 or -2^(W-1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  W  operand bus, sampled on load.
- load  in  1  single-cycle strobe; captures data_in as the next operand.
- op_add  in  1  single-cycle strobe; start signed add.
- op_mul  in  1  single-cycle strobe; start signed multiply.
- result  out  W  last completed result.
- overflow  out  1  overflow flag of last completed operation.
- state  out  3  current FSM state, for LEDs.
- busy  out  1  high while in MULT.
- done  out  1  one-cycle pulse in the first cycle of RESULT.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, operands=0, result=0, overflow=0, done=0, busy=0, mult counter=0. Reset mid-MULT aborts the operation; no result update.
- State encoding: IDLE=0, WAIT_B=1, WAIT_OP=2, MULT=3, RESULT=4. Values 5-7 are unreachable and go to IDLE.
- IDLE: load -> capture A, go to WAIT_B. op_add/op_mul ignored.
- WAIT_B: load -> capture B, go to WAIT_OP. op strobes ignored.
- WAIT_OP:
  - op_mul -> go to MULT, counter=0.
  - else op_add -> compute sum, go to RESULT.
  - op_mul has priority when both strobes are high. Any op strobe takes priority over a simultaneous load; load is ignored in this state.
- MULT:
  - Exactly W cycles, one multiplier bit per cycle, operating on |A|·|B| into a 2W-bit accumulator.
  - At the edge ending the W-th cycle: go to RESULT, register result and overflow.
  - All strobes ignored while busy=1.
- RESULT:
  - result and overflow held stable.
  - load -> capture new A, go to WAIT_B; result and overflow unchanged until the next done.
  - op strobes ignored.
- Latency, measured from the edge that samples the op strobe to the edge entering RESULT:
  - add = 1 cycle.
  - mul = W+1 cycles (W MULT cycles plus the transition).
  - done is high for exactly the first RESULT cycle.
- Add:
  - s = sign-extended A + B (W+1 bits).
  - overflow = s[W] xor s[W-1].
  - SAT=0: result = s[W-1:0].
  - SAT=1 with overflow: result = 2^(W-1)-1 if s[W]=0, else -2^(W-1).
- Multiply:
  - neg = A[W-1] xor B[W-1].
  - |x| is formed as a W-bit unsigned value, so |-2^(W-1)| = 2^(W-1).
  - P = |A|·|B| (2W bits); M = P >> FRAC (truncation toward zero on magnitude).
  - overflow = (M > 2^(W-1)-1 when neg=0) or (M > 2^(W-1) when neg=1).
  - SAT=0: result = low W bits of (neg ? -M : M).
  - SAT=1 with overflow: saturate per sign.
  - A zero product always gives result 0 with overflow 0.
- Outputs are registered; no combinational path from inputs to result, overflow, state or done.

Test Plan (W=16, FRAC=8):
- Reset mid-MULT: after 5 MULT cycles, pulse rst low -> state=0, result=0, overflow=0, no done pulse.
- Basic add: load 0x0180, load 0x0240, op_add -> done exactly 1 cycle after op, result=0x03C0, overflow=0.
- Basic multiply: same operands, op_mul -> busy for 16 cycles, done at op+17, result=0x0360, overflow=0.
- Signed and edge-of-range multiply:
  - 0xFE80 x 0x0240 -> 0xFCA0, overflow=0.
  - 0x8000 x 0x0100 -> 0x8000, overflow=0.
  - 0x0001 x 0x0001 -> 0x0000, overflow=0 (truncation).
- Overflow handling:
  - Add 0x7F00 + 0x0200: SAT=0 -> 0x8100, overflow=1; SAT=1 -> 0x7FFF, overflow=1.
  - Multiply 0x4000 x 0x0200: SAT=0 -> 0x8000, overflow=1; SAT=1 -> 0x7FFF, overflow=1.
- Strobe arbitration:
  - op_add and op_mul together in WAIT_OP -> multiply performed.
  - load together with op in WAIT_OP -> load ignored.
  - load in RESULT -> state=1, result unchanged.
  - op strobes in IDLE or WAIT_B -> no state change.
